pipelined_addsub_64: RTL and testbench

- Registered 64-bit add/subtract unit; pipelined companion to the combinational 64-bit CLA adder.
- Operands enter through a valid/ready handshake. The carry ripples across 16-bit CLA slices, one slice per pipeline stage.
- Results leave through a valid/ready handshake. The datapath block owns a full-rate adder and subtractor with bounded latency and backpressure.

---
 rtl/addsub_pkg.sv | 12 +
 rtl/pipelined_addsub_64_cla_slice.sv | 54 +++++
 rtl/pipelined_addsub_64.sv | 131 +++++++++++++
 tb/tb_pipelined_addsub_64.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared constants for the pipelined add/subtract unit.
// Operand width, slice width and the op encoding.
package addsub_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int SLICE_DEF = 16;
  localparam int STAGES    = WIDTH_DEF / SLICE_DEF;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/pipelined_addsub_64_cla_slice.sv
// Combinational SLICE-bit carry-lookahead adder slice.
// 4-bit lookahead groups, group carries chained across the slice.
module cla_slice #(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  localparam int GRP = 4;
  localparam int NG  = SLICE / GRP;

  logic [SLICE-1:0] p;
  logic [SLICE-1:0] g;
  logic [SLICE:0]   c;
  logic [NG-1:0]    gp;
  logic [NG-1:0]    gg;
  logic [NG:0]      gc;

  // Group propagate/generate, group carries, then bit carries inside groups.
  always_comb begin
    p  = a ^ b;
    g  = a & b;
    gp = '0;
    gg = '0;
    gc = '0;
    c  = '0;
    for (int i = 0; i < NG; i++) begin
      gp[i] = &p[i*GRP +: GRP];
      for (int j = 0; j < GRP; j++) begin
        gg[i] = g[i*GRP+j] | (p[i*GRP+j] & gg[i]);
      end
    end
    gc[0] = ci;
    for (int i = 0; i < NG; i++) begin
      gc[i+1] = gg[i] | (gp[i] & gc[i]);
    end
    for (int i = 0; i < NG; i++) begin
      c[i*GRP] = gc[i];
      for (int j = 1; j < GRP; j++) begin
        c[i*GRP+j] = g[i*GRP+j-1] | (p[i*GRP+j-1] & c[i*GRP+j-1]);
      end
    end
    c[SLICE] = gc[NG];
    s        = p ^ c[SLICE-1:0];
    co       = c[SLICE];
    c_msb_in = c[SLICE-1];
  end

endmodule

// File: rtl/pipelined_addsub_64.sv
// Pipelined 64-bit add/subtract, one CLA slice per stage.
// Global-stall valid/ready pipeline; outputs hold between results.
module pipelined_addsub_64
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STG = WIDTH / SLICE;

  // index 0 is the operand capture; index STG is the output
  logic [STG:0]     v_q, v_d;
  logic [WIDTH-1:0] a_q [STG];
  logic [WIDTH-1:0] a_d [STG];
  logic [WIDTH-1:0] b_q [STG];
  logic [WIDTH-1:0] b_d [STG];
  logic [STG-1:0]   sub_q, sub_d;
  logic [STG:0]     c_q, c_d;
  logic [WIDTH-1:0] s_q [1:STG];
  logic [WIDTH-1:0] s_d [1:STG];
  logic             cm_q, cm_d;

  logic [SLICE-1:0] sl_s  [STG];
  logic             sl_co [STG];
  logic             sl_cm [STG];

  logic adv;

  assign adv       = !v_q[STG] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[STG];
  assign sum       = s_q[STG];
  assign cout      = c_q[STG];
  assign ovf       = c_q[STG] ^ cm_q;

  for (genvar k = 0; k < STG; k++) begin : g_slice
    cla_slice #(
      .SLICE(SLICE)
    ) u_slice (
      .a       (a_q[k][k*SLICE +: SLICE]),
      .b       (b_q[k][k*SLICE +: SLICE] ^ {SLICE{sub_q[k]}}),
      .ci      (c_q[k]),
      .s       (sl_s[k]),
      .co      (sl_co[k]),
      .c_msb_in(sl_cm[k])
    );
  end

  // Next state: all stages shift together on adv, data moves only if valid.
  always_comb begin
    v_d   = v_q;
    a_d   = a_q;
    b_d   = b_q;
    sub_d = sub_q;
    c_d   = c_q;
    s_d   = s_q;
    cm_d  = cm_q;
    if (adv) begin
      v_d[0] = in_valid;
      if (in_valid) begin
        a_d[0]   = in_a;
        b_d[0]   = in_b;
        sub_d[0] = sub;
        c_d[0]   = cin ^ sub;
      end
      for (int j = 1; j <= STG; j++) begin
        v_d[j] = v_q[j-1];
        if (v_q[j-1]) c_d[j] = sl_co[j-1];
      end
      for (int j = 1; j < STG; j++) begin
        if (v_q[j-1]) begin
          a_d[j]   = a_q[j-1];
          b_d[j]   = b_q[j-1];
          sub_d[j] = sub_q[j-1];
        end
      end
      if (v_q[0]) begin
        s_d[1]            = '0;
        s_d[1][SLICE-1:0] = sl_s[0];
      end
      for (int j = 2; j <= STG; j++) begin
        if (v_q[j-1]) begin
          s_d[j]                    = s_q[j-1];
          s_d[j][(j-1)*SLICE +: SLICE] = sl_s[j-1];
        end
      end
      if (v_q[STG-1]) cm_d = sl_cm[STG-1];
    end
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      v_q   <= '0;
      sub_q <= '0;
      c_q   <= '0;
      cm_q  <= 1'b0;
      for (int j = 0; j < STG; j++) begin
        a_q[j] <= '0;
        b_q[j] <= '0;
      end
      for (int j = 1; j <= STG; j++) begin
        s_q[j] <= '0;
      end
    end else begin
      v_q   <= v_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sub_q <= sub_d;
      c_q   <= c_d;
      s_q   <= s_d;
      cm_q  <= cm_d;
    end
  end

endmodule

// File: tb/tb_pipelined_addsub_64.sv
// Directed and random checks for pipelined_addsub_64.
// Inputs driven and outputs sampled on the falling edge.
module tb_pipelined_addsub_64;
  import addsub_pkg::*;

  logic        CLK = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  pipelined_addsub_64 dut (
    .CLK      (CLK),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  always #5 CLK = ~CLK;

  // Issue one op with out_ready high, wait for its result.
  task automatic send_one(
    input  logic [63:0] a, b,
    input  logic        ci, sb,
    output logic [63:0] rs,
    output logic        rc, ro,
    output int          lat,
    output logic        pulse_after
  );
    @(negedge CLK);
    in_valid = 1'b1; in_a = a; in_b = b;
    cin = ci; sub = sb; out_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0; in_a = ~a; in_b = ~b; cin = ~ci;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    rs = sum; rc = cout; ro = ovf;
    @(negedge CLK);
    pulse_after = out_valid;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0;
    cin = 1'b0; sub = OP_ADD; out_ready = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (sum !== 64'd0) begin errors++; $display("FAIL reset_sum got %h want 0", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add_wrap;
    logic [63:0] rs; logic rc, ro, pa; int lat;
    send_one(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, OP_ADD, rs, rc, ro, lat, pa);
    checks++; if (lat !== 4) begin errors++; $display("FAIL wrap_latency got %0d want 4", lat); end
    checks++; if (rs !== 64'd0) begin errors++; $display("FAIL wrap_sum got %h want 0", rs); end
    checks++; if (rc !== 1'b1) begin errors++; $display("FAIL wrap_cout got %b want 1", rc); end
    checks++; if (ro !== 1'b0) begin errors++; $display("FAIL wrap_ovf got %b want 0", ro); end
    checks++; if (pa !== 1'b0) begin errors++; $display("FAIL wrap_pulse got %b want 0", pa); end
  endtask

  task automatic test_sub_borrow;
    logic [63:0] rs; logic rc, ro, pa; int lat;
    send_one(64'd5, 64'd7, 1'b0, OP_SUB, rs, rc, ro, lat, pa);
    checks++; if (rs !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub1_sum got %h want fffffffffffffffe", rs); end
    checks++; if (rc !== 1'b0) begin errors++; $display("FAIL sub1_cout got %b want 0", rc); end
    checks++; if (ro !== 1'b0) begin errors++; $display("FAIL sub1_ovf got %b want 0", ro); end
    send_one(64'd7, 64'd5, 1'b1, OP_SUB, rs, rc, ro, lat, pa);
    checks++; if (rs !== 64'd1) begin errors++; $display("FAIL sub2_sum got %h want 1", rs); end
    checks++; if (rc !== 1'b1) begin errors++; $display("FAIL sub2_cout got %b want 1", rc); end
  endtask

  task automatic test_overflow;
    logic [63:0] rs; logic rc, ro, pa; int lat;
    send_one(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, OP_ADD, rs, rc, ro, lat, pa);
    checks++; if (rs !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_add_sum got %h want 8000000000000000", rs); end
    checks++; if (rc !== 1'b0) begin errors++; $display("FAIL ovf_add_cout got %b want 0", rc); end
    checks++; if (ro !== 1'b1) begin errors++; $display("FAIL ovf_add_ovf got %b want 1", ro); end
    send_one(64'h8000_0000_0000_0000, 64'd1, 1'b0, OP_SUB, rs, rc, ro, lat, pa);
    checks++; if (rs !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL ovf_sub_sum got %h want 7fffffffffffffff", rs); end
    checks++; if (rc !== 1'b1) begin errors++; $display("FAIL ovf_sub_cout got %b want 1", rc); end
    checks++; if (ro !== 1'b1) begin errors++; $display("FAIL ovf_sub_ovf got %b want 1", ro); end
  endtask

  task automatic test_full_rate;
    logic [63:0] va [4];
    logic [63:0] vb [4];
    logic        vc [4];
    logic [63:0] ex [4];
    logic [63:0] got [$];
    int          at [$];
    va = '{64'h0000_0000_0000_FFFF, 64'h0000_FFFF_FFFF_FFFF, 64'd3, 64'd0};
    vb = '{64'd1, 64'd1, 64'd4, 64'd0};
    vc = '{1'b0, 1'b0, 1'b0, 1'b1};
    ex = '{64'h1_0000, 64'h1_0000_0000_0000, 64'd7, 64'd1};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      in_valid = 1'b1; in_a = va[i]; in_b = vb[i];
      cin = vc[i]; sub = OP_ADD;
    end
    @(negedge CLK);
    in_valid = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (out_valid) begin
        got.push_back(sum);
        at.push_back(t);
      end
      @(negedge CLK);
    end
    checks++; if (got.size() !== 4) begin errors++; $display("FAIL rate_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== ex[i]) begin errors++; $display("FAIL rate_sum%0d got %h want %h", i, got[i], ex[i]); end
      checks++; if (at[i] !== 1 + i) begin errors++; $display("FAIL rate_slot%0d got %0d want %0d", i, at[i], 1 + i); end
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] ex [4];
    logic [63:0] got [$];
    int          k;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      in_valid = 1'b1; in_a = 64'(100 + i);
      in_b = 64'h1_0000_0000; cin = 1'b0; sub = OP_ADD;
      ex[i] = 64'h1_0000_0000 + 64'(100 + i);
    end
    @(negedge CLK);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 10) begin
      @(negedge CLK);
      k++;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid got %b want 1", out_valid); end
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 64'hDEAD; in_b = 64'hBEEF; sub = OP_SUB;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid%0d got %b want 1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got %b want 0", i, in_ready); end
      checks++; if (sum !== ex[0]) begin errors++; $display("FAIL bp_hold_sum%0d got %h want %h", i, sum, ex[0]); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if (out_valid && out_ready) got.push_back(sum);
      @(negedge CLK);
    end
    checks++; if (got.size() !== 4) begin errors++; $display("FAIL bp_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== ex[i]) begin errors++; $display("FAIL bp_sum%0d got %h want %h", i, got[i], ex[i]); end
    end
  endtask

  task automatic test_reset_midflight;
    logic [63:0] rs; logic rc, ro, pa; int lat;
    logic        seen;
    out_ready = 1'b1;
    @(negedge CLK);
    in_valid = 1'b1; in_a = 64'hFFFF_FFFF_FFFF_FFFF;
    in_b = 64'hFFFF_FFFF_FFFF_FFFF; cin = 1'b1; sub = OP_ADD;
    @(negedge CLK);
    in_a = 64'h7FFF_FFFF_FFFF_FFFF; in_b = 64'd1; cin = 1'b0;
    @(negedge CLK);
    in_valid = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
    checks++; if (sum !== 64'd0) begin errors++; $display("FAIL mid_sum got %h want 0", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL mid_cout got %b want 0", cout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b want 0", ovf); end
    @(negedge CLK);
    reset = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge CLK);
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_stale got %b want 0", seen); end
    send_one(64'd10, 64'd20, 1'b0, OP_ADD, rs, rc, ro, lat, pa);
    checks++; if (rs !== 64'd30) begin errors++; $display("FAIL mid_new_sum got %h want 1e", rs); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL mid_new_latency got %0d want 4", lat); end
  endtask

  task automatic test_random;
    logic [65:0] q [$];
    logic [65:0] e;
    logic [64:0] r;
    logic [63:0] bb;
    int          accepted;
    int          cyc;
    accepted = 0;
    cyc = 0;
    @(negedge CLK);
    while (accepted < 10000 && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = {$urandom, $urandom};
      in_b      = {$urandom, $urandom};
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_extra got %h want none", sum);
        end else begin
          e = q.pop_front();
          if ({ovf, cout, sum} !== e) begin
            errors++; $display("FAIL rnd_result got %h want %h", {ovf, cout, sum}, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        bb = sub ? ~in_b : in_b;
        if (sub) r = {1'b0, in_a} + {1'b0, ~in_b} + {64'd0, ~cin};
        else     r = {1'b0, in_a} + {1'b0, in_b} + {64'd0, cin};
        q.push_back({(in_a[63] == bb[63]) && (r[63] != in_a[63]), r});
        accepted++;
      end
      @(negedge CLK);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() > 0 && cyc < 40100) begin
      #1;
      if (out_valid) begin
        checks++;
        e = q.pop_front();
        if ({ovf, cout, sum} !== e) begin
          errors++; $display("FAIL rnd_result got %h want %h", {ovf, cout, sum}, e);
        end
      end
      @(negedge CLK);
      cyc++;
    end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL rnd_drain got %0d left want 0", q.size()); end
    checks++; if (accepted !== 10000) begin errors++; $display("FAIL rnd_accepted got %0d want 10000", accepted); end
  endtask

  initial begin
    test_reset;
    test_add_wrap;
    test_sub_borrow;
    test_overflow;
    test_full_rate;
    test_backpressure;
    test_reset_midflight;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
